// File: rtl/bit_packer_stream_if.sv
// Beat-in / word-out stream bundle for bit_packer_stream, plus the frame status outputs.
// The slave modport is the packer's view; master is the view of whatever drives and drains it.
interface bit_packer_stream_if #(
   parameter int CHANNELS = 4,
   parameter int WORD_W   = 8
);
   localparam int NB_W = $clog2(WORD_W + 1);

   logic                in_valid;
   logic                in_ready;
   logic [CHANNELS-1:0] in_bits;
   logic                in_last;

   logic                out_valid;
   logic                out_ready;
   logic [WORD_W-1:0]   out_data;
   logic [NB_W-1:0]     out_nbits;
   logic                out_last;

   logic                frame_done;
   logic [15:0]         word_count;

   modport slave (
      input  in_valid, in_bits, in_last, out_ready,
      output in_ready, out_valid, out_data, out_nbits, out_last, frame_done, word_count
   );

   modport master (
      output in_valid, in_bits, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_nbits, out_last, frame_done, word_count
   );
endinterface

// File: rtl/bit_packer_stream.sv
// Packs CHANNELS-bit binary beats into WORD_W-bit words; in_last flushes a partial word with its bit count.
// A word is visible the cycle after its completing beat; in_ready drops only while a held word waits on out_ready.
module bit_packer_stream #(
   parameter int CHANNELS  = 4,
   parameter int WORD_W    = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   bit_packer_stream_if.slave   bus
);
   localparam int NB_W = $clog2(WORD_W + 1);
   localparam logic [NB_W-1:0] STEP = NB_W'(CHANNELS);
   localparam logic [NB_W-1:0] FULL = NB_W'(WORD_W);

   generate
      if (CHANNELS < 1 || CHANNELS > 16 || (WORD_W % CHANNELS) != 0) begin : g_bad_params
         $error("bit_packer_stream: CHANNELS must be 1..16 and divide WORD_W");
      end
   endgenerate

   logic [WORD_W-1:0] acc;
   logic [NB_W-1:0]   fill;
   logic [WORD_W-1:0] beat_word;
   logic [WORD_W-1:0] merged;
   logic [NB_W-1:0]   fill_next;

   logic [WORD_W-1:0] out_data_q;
   logic [NB_W-1:0]   out_nbits_q;
   logic              out_valid_q;
   logic              out_last_q;
   logic              frame_done_q;
   logic [15:0]       word_count_q;

   logic in_ready_c;
   logic accept;
   logic complete;
   logic out_xfer;

   // The beat is first laid out as if fill were 0, then shifted into place.
   always_comb begin
      beat_word = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (MSB_FIRST)
            beat_word[WORD_W-1-i] = bus.in_bits[i];
         else
            beat_word[i] = bus.in_bits[i];
      end
      if (MSB_FIRST)
         merged = acc | (beat_word >> fill);
      else
         merged = acc | (beat_word << fill);
   end

   assign in_ready_c = !reset && (!out_valid_q || bus.out_ready);
   assign accept     = bus.in_valid && in_ready_c;
   assign fill_next  = fill + STEP;
   assign complete   = (fill_next == FULL) || bus.in_last;
   assign out_xfer   = out_valid_q && bus.out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc          <= '0;
         fill         <= '0;
         out_data_q   <= '0;
         out_nbits_q  <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
         word_count_q <= '0;
      end else begin
         if (accept) begin
            if (complete) begin
               out_data_q  <= merged;
               out_nbits_q <= fill_next;
               out_last_q  <= bus.in_last;
               acc         <= '0;
               fill        <= '0;
            end else begin
               acc  <= merged;
               fill <= fill_next;
            end
         end

         // A completing beat in the same cycle as a transfer keeps valid high.
         if (accept && complete)
            out_valid_q <= 1'b1;
         else if (out_xfer)
            out_valid_q <= 1'b0;

         frame_done_q <= out_xfer && out_last_q;

         // The next frame's first word may already transfer while frame_done is high.
         if (frame_done_q)
            word_count_q <= out_xfer ? 16'd1 : 16'd0;
         else if (out_xfer && word_count_q != 16'hFFFF)
            word_count_q <= word_count_q + 16'd1;
      end
   end

   assign bus.in_ready   = in_ready_c;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.out_nbits  = out_nbits_q;
   assign bus.out_last   = out_last_q;
   assign bus.frame_done = frame_done_q;
   assign bus.word_count = word_count_q;
endmodule

// File: tb/tb_bit_packer_stream.sv
// Bench for bit_packer_stream: LSB and MSB 4x8 packers fed the same stream, plus a 2x16 packer with its own reset.
// A stream-level reference model predicts every output each cycle; directed beats cover the documented cases.
module tb_bit_packer_stream;
   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic rst_c = 1'b1;
   int   cyc   = 0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bit_packer_stream_if #(.CHANNELS(4), .WORD_W(8))  ifa ();
   bit_packer_stream_if #(.CHANNELS(4), .WORD_W(8))  ifb ();
   bit_packer_stream_if #(.CHANNELS(2), .WORD_W(16)) ifc ();

   assign ifb.in_valid  = ifa.in_valid;
   assign ifb.in_bits   = ifa.in_bits;
   assign ifb.in_last   = ifa.in_last;
   assign ifb.out_ready = ifa.out_ready;

   bit_packer_stream #(.CHANNELS(4), .WORD_W(8),  .MSB_FIRST(1'b0)) u_lsb  (.clk(clk), .reset(reset), .bus(ifa.slave));
   bit_packer_stream #(.CHANNELS(4), .WORD_W(8),  .MSB_FIRST(1'b1)) u_msb  (.clk(clk), .reset(reset), .bus(ifb.slave));
   bit_packer_stream #(.CHANNELS(2), .WORD_W(16), .MSB_FIRST(1'b0)) u_wide (.clk(clk), .reset(rst_c), .bus(ifc.slave));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Reference model state, one slot per instance: stream bits of the open word and the pending output word.
   int          ww[3] = '{8, 8, 16};
   int          cc[3] = '{4, 4, 2};
   bit          mm[3] = '{1'b0, 1'b1, 1'b0};
   logic [15:0] strm[3];
   int          nfill[3];
   bit          pv[3];
   logic [15:0] pd[3];
   int          pnb[3];
   bit          pl[3];
   bit          mfd[3];
   int          mwc[3];

   function automatic logic [15:0] form_word(input logic [15:0] s, input int n, input int w, input bit msb);
      logic [15:0] r;
      r = '0;
      for (int j = 0; j < n; j++) begin
         if (msb) r[w-1-j] = s[j];
         else     r[j]     = s[j];
      end
      return r;
   endfunction

   task automatic step(input int k, input logic rst, input logic ov, input logic ordy,
                       input logic [15:0] od, input logic [4:0] onb, input logic ol,
                       input logic fd, input logic [15:0] wc, input logic iv,
                       input logic irdy, input logic [15:0] ib, input logic il);
      string p;
      bit hs, take, prev_fd;
      p = $sformatf("u%0d.", k);
      if (rst) begin
         check_eq({p, "rst_in_ready"},  irdy, 0);
         check_eq({p, "rst_out_valid"}, ov,   0);
         check_eq({p, "rst_out_data"},  od,   0);
         check_eq({p, "rst_out_nbits"}, onb,  0);
         check_eq({p, "rst_out_last"},  ol,   0);
         check_eq({p, "rst_frame_done"}, fd,  0);
         check_eq({p, "rst_word_count"}, wc,  0);
         strm[k] = '0; nfill[k] = 0; pv[k] = 0; mfd[k] = 0; mwc[k] = 0;
         return;
      end
      check_eq({p, "in_ready"},  irdy, !pv[k] || ordy);
      check_eq({p, "out_valid"}, ov,   pv[k]);
      if (pv[k]) begin
         check_eq({p, "out_data"},  od,  pd[k]);
         check_eq({p, "out_nbits"}, onb, pnb[k]);
         check_eq({p, "out_last"},  ol,  pl[k]);
      end
      check_eq({p, "frame_done"}, fd, mfd[k]);
      check_eq({p, "word_count"}, wc, mwc[k]);

      hs      = pv[k] && ordy;
      take    = iv && (!pv[k] || ordy);
      prev_fd = mfd[k];
      mfd[k]  = hs && pl[k];
      if (prev_fd) mwc[k] = 0;
      if (hs) begin
         if (mwc[k] < 65535) mwc[k]++;
         pv[k] = 0;
      end
      if (take) begin
         for (int i = 0; i < cc[k]; i++) strm[k][nfill[k]+i] = ib[i];
         nfill[k] += cc[k];
         if (nfill[k] == ww[k] || il) begin
            pd[k]    = form_word(strm[k], nfill[k], ww[k], mm[k]);
            pnb[k]   = nfill[k];
            pl[k]    = il;
            pv[k]    = 1;
            strm[k]  = '0;
            nfill[k] = 0;
         end
      end
   endtask

   always @(negedge clk) begin
      step(0, reset, ifa.out_valid, ifa.out_ready, 16'(ifa.out_data), 5'(ifa.out_nbits), ifa.out_last,
           ifa.frame_done, ifa.word_count, ifa.in_valid, ifa.in_ready, 16'(ifa.in_bits), ifa.in_last);
      step(1, reset, ifb.out_valid, ifb.out_ready, 16'(ifb.out_data), 5'(ifb.out_nbits), ifb.out_last,
           ifb.frame_done, ifb.word_count, ifb.in_valid, ifb.in_ready, 16'(ifb.in_bits), ifb.in_last);
      step(2, rst_c, ifc.out_valid, ifc.out_ready, 16'(ifc.out_data), 5'(ifc.out_nbits), ifc.out_last,
           ifc.frame_done, ifc.word_count, ifc.in_valid, ifc.in_ready, 16'(ifc.in_bits), ifc.in_last);
   end

   // Beat tasks leave in_valid high so consecutive calls stream at full rate.
   task automatic beat_a(input logic [3:0] b, input logic l);
      bit got;
      got = 0;
      ifa.in_valid = 1'b1; ifa.in_bits = b; ifa.in_last = l;
      for (int t = 0; t < 200 && !got; t++) begin
         @(negedge clk);
         if (ifa.in_ready) got = 1;
      end
      check_eq("a.accept", got, 1);
      @(posedge clk); #1;
   endtask

   task automatic idle_a();
      ifa.in_valid = 1'b0; ifa.in_last = 1'b0;
   endtask

   task automatic beat_c(input logic [1:0] b, input logic l);
      bit got;
      got = 0;
      ifc.in_valid = 1'b1; ifc.in_bits = b; ifc.in_last = l;
      for (int t = 0; t < 200 && !got; t++) begin
         @(negedge clk);
         if (ifc.in_ready) got = 1;
      end
      check_eq("c.accept", got, 1);
      @(posedge clk); #1;
   endtask

   task automatic idle_c();
      ifc.in_valid = 1'b0; ifc.in_last = 1'b0;
   endtask

   task automatic run_ab();
      int wc0, start;
      bit done;
      ifa.out_ready = 1'b1;

      beat_a(4'h6, 1'b1); idle_a();
      check_eq("flush_data", ifa.out_data, 8'h06);
      check_eq("flush_nbits", ifa.out_nbits, 4);
      check_eq("flush_last", ifa.out_last, 1);
      check_eq("flush_msb_data", ifb.out_data, 8'h60);
      @(posedge clk); #1;
      check_eq("flush_frame_done", ifa.frame_done, 1);
      check_eq("flush_word_count", ifa.word_count, 1);
      @(posedge clk); #1;
      check_eq("flush_frame_done_end", ifa.frame_done, 0);
      check_eq("flush_word_count_clr", ifa.word_count, 0);

      beat_a(4'hA, 1'b0); beat_a(4'h5, 1'b0); idle_a();
      check_eq("lsb_valid", ifa.out_valid, 1);
      check_eq("lsb_5a", ifa.out_data, 8'h5A);
      check_eq("lsb_nbits", ifa.out_nbits, 8);
      check_eq("lsb_last", ifa.out_last, 0);

      beat_a(4'h1, 1'b0); beat_a(4'h0, 1'b0); idle_a();
      check_eq("order_lsb_01", ifa.out_data, 8'h01);
      check_eq("order_msb_80", ifb.out_data, 8'h80);

      repeat (2) @(posedge clk); #1;
      wc0 = int'(ifa.word_count);
      beat_a(4'h3, 1'b0); beat_a(4'hC, 1'b1); idle_a();
      check_eq("exact_data", ifa.out_data, 8'hC3);
      check_eq("exact_nbits", ifa.out_nbits, 8);
      check_eq("exact_last", ifa.out_last, 1);
      @(posedge clk); #1;
      check_eq("exact_frame_done", ifa.frame_done, 1);
      check_eq("exact_word_count", ifa.word_count, wc0 + 1);

      ifa.out_ready = 1'b0;
      beat_a(4'hA, 1'b0); beat_a(4'h5, 1'b0);
      ifa.in_bits = 4'($urandom_range(0, 15));
      repeat (3) begin
         @(negedge clk);
         check_eq("hold_in_ready", ifa.in_ready, 0);
         check_eq("hold_data", ifa.out_data, 8'h5A);
      end
      @(posedge clk); #1;
      ifa.out_ready = 1'b1;
      start = cyc;
      for (int i = 0; i < 16; i++) beat_a(4'($urandom_range(0, 15)), 1'b0);
      check_eq("full_rate_cycles", cyc - start, 16);
      idle_a();

      done = 0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(0, 5) == 0) begin idle_a(); @(posedge clk); #1; end
               beat_a(4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
            end
            idle_a();
            done = 1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               ifa.out_ready = ($urandom_range(0, 3) != 0);
            end
            ifa.out_ready = 1'b1;
         end
      join
      repeat (4) @(posedge clk); #1;
   endtask

   task automatic run_c();
      bit done;
      ifc.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) beat_c(2'($urandom_range(0, 3)), 1'b0);
      idle_c();
      @(posedge clk); #1;
      rst_c = 1'b1;
      @(posedge clk); #1;
      check_eq("c.rst_mid_valid", ifc.out_valid, 0);
      check_eq("c.rst_mid_data", ifc.out_data, 0);
      rst_c = 1'b0;
      for (int i = 0; i < 8; i++) beat_c(2'b11, 1'b0);
      idle_c();
      check_eq("c.after_rst_data", ifc.out_data, 16'hFFFF);
      check_eq("c.after_rst_nbits", ifc.out_nbits, 16);

      done = 0;
      fork
         begin
            for (int i = 0; i < 200; i++) begin
               if ($urandom_range(0, 5) == 0) begin idle_c(); @(posedge clk); #1; end
               beat_c(2'($urandom_range(0, 3)), $urandom_range(0, 5) == 0);
            end
            idle_c();
            done = 1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               ifc.out_ready = ($urandom_range(0, 2) != 0);
            end
            ifc.out_ready = 1'b1;
         end
      join
      repeat (4) @(posedge clk); #1;
   endtask

   initial begin
      ifa.in_valid = 1'b0; ifa.in_bits = '0; ifa.in_last = 1'b0; ifa.out_ready = 1'b1;
      ifc.in_valid = 1'b0; ifc.in_bits = '0; ifc.in_last = 1'b0; ifc.out_ready = 1'b1;
      repeat (3) @(posedge clk); #1;
      reset = 1'b0;
      rst_c = 1'b0;
      fork
         run_ab();
         run_c();
      join
      repeat (3) @(posedge clk); #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule
